// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
// The CLA group width is fixed at 4 bits; operand widths must be a whole number of groups.
package cla_pkg;

  localparam int GRP_W = 4;

  typedef logic [GRP_W-1:0] slice_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  function automatic bit cla_check_width(int n);
    return (n > 0) && ((n % GRP_W) == 0);
  endfunction

endpackage

// File: rtl/cla4_group.sv
// Combinational 4-bit carry-lookahead group: flattened lookahead carries,
// plus group generate/propagate so a caller can chain groups either way.
module cla4_group
  import cla_pkg::*;
(
  input  slice_t a,
  input  slice_t b,
  input  logic   c_in,
  output slice_t s,
  output logic   c_out,
  output logic   gp,
  output logic   pp
);

  slice_t g;
  slice_t p;
  slice_t c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    gp   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pp   = &p;
    c_out = gp | (pp & c_in);
    s    = p ^ c;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor: stage i adds slice i with the carry registered by stage i-1.
// Define CLA_PIPE_FLAGS_EN to add the registered ovf/zero result flags.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int nBITS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [nBITS-1:0] ain,
  input  logic [nBITS-1:0] bin,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [nBITS-1:0] sum,
  output logic             cout
`ifdef CLA_PIPE_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  localparam int NGRP = nBITS / GRP_W;

  if (!cla_check_width(nBITS)) begin : g_width_check
    $error("cla_pipe_adder: nBITS=%0d is not a positive multiple of %0d", nBITS, GRP_W);
  end

  typedef logic [nBITS-1:0] word_t;

  op_t    op;
  logic   advance;
  logic   accept;

  // Stage inputs: what stage i sees this cycle (stage 0 sees the ports).
  word_t  st_a [NGRP];
  word_t  st_b [NGRP];
  word_t  st_s [NGRP];
  logic   st_c [NGRP];
  logic   st_v [NGRP];

  slice_t grp_s    [NGRP];
  logic   grp_cout [NGRP];
  logic   grp_gp   [NGRP];
  logic   grp_pp   [NGRP];

  word_t  a_d [NGRP];
  word_t  a_q [NGRP];
  word_t  b_d [NGRP];
  word_t  b_q [NGRP];
  word_t  s_d [NGRP];
  word_t  s_q [NGRP];
  logic   c_d [NGRP];
  logic   c_q [NGRP];
  logic   v_d [NGRP];
  logic   v_q [NGRP];

  assign op       = op_t'(sub);
  assign advance  = !v_q[NGRP-1] || out_ready;
  assign in_ready = advance && !reset;
  assign accept   = in_valid && in_ready;

  always_comb begin
    st_a[0] = ain;
    st_b[0] = (op == OP_SUB) ? ~bin : bin;
    st_c[0] = (op == OP_SUB) ? 1'b1 : cin;
    st_s[0] = '0;
    st_v[0] = accept;
    for (int i = 1; i < NGRP; i++) begin
      st_a[i] = a_q[i-1];
      st_b[i] = b_q[i-1];
      st_s[i] = s_q[i-1];
      st_c[i] = c_q[i-1];
      st_v[i] = v_q[i-1];
    end
  end

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    cla4_group u_grp (
      .a     (st_a[g][g*GRP_W +: GRP_W]),
      .b     (st_b[g][g*GRP_W +: GRP_W]),
      .c_in  (st_c[g]),
      .s     (grp_s[g]),
      .c_out (grp_cout[g]),
      .gp    (grp_gp[g]),
      .pp    (grp_pp[g])
    );
  end

  // c_out and G|P&c_in are the same carry; combining them keeps both group paths live.
  always_comb begin
    for (int i = 0; i < NGRP; i++) begin
      a_d[i] = a_q[i];
      b_d[i] = b_q[i];
      s_d[i] = s_q[i];
      c_d[i] = c_q[i];
      v_d[i] = v_q[i];
      if (advance) begin
        a_d[i] = st_a[i];
        b_d[i] = st_b[i];
        s_d[i] = st_s[i];
        s_d[i][i*GRP_W +: GRP_W] = grp_s[i];
        c_d[i] = grp_cout[i] | grp_gp[i] | (grp_pp[i] & st_c[i]);
        v_d[i] = st_v[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NGRP; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        s_q[i] <= '0;
        c_q[i] <= 1'b0;
        v_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NGRP; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
        s_q[i] <= s_d[i];
        c_q[i] <= c_d[i];
        v_q[i] <= v_d[i];
      end
    end
  end

  assign out_valid = v_q[NGRP-1];
  assign sum       = s_q[NGRP-1];
  assign cout      = c_q[NGRP-1];

`ifdef CLA_PIPE_FLAGS_EN
  logic  ovf_d;
  logic  ovf_q;
  logic  zero_d;
  logic  zero_q;
  word_t fin_sum;

  // Flags come from the final stage's fully assembled sum and its operand MSBs.
  always_comb begin
    fin_sum = st_s[NGRP-1];
    fin_sum[(NGRP-1)*GRP_W +: GRP_W] = grp_s[NGRP-1];
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (advance) begin
      ovf_d  = (st_a[NGRP-1][nBITS-1] == st_b[NGRP-1][nBITS-1]) &&
               (fin_sum[nBITS-1] != st_a[NGRP-1][nBITS-1]);
      zero_d = ~|fin_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder (nBITS=16, four stages): single ops, streaming,
// backpressure and mid-flight reset; flag checks are added when CLA_PIPE_FLAGS_EN is defined.
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ain;
  logic [15:0] bin;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef CLA_PIPE_FLAGS_EN
  logic        ovf;
  logic        zero;
`endif

  int total = 0;
  int bad   = 0;

  // Hand-computed beats: A, B, cin, sub -> expected sum, cout.
  logic [15:0] va  [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0000, 16'h0F0F, 16'hABCD, 16'h1000, 16'h00FF};
  logic [15:0] vb  [8] = '{16'h4321, 16'hFFFF, 16'h0001, 16'h0001, 16'hF0F0, 16'h1234, 16'h1000, 16'h0001};
  logic        vci [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        vsb [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [15:0] vs  [8] = '{16'h5555, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h0000, 16'hBE01, 16'h0000, 16'h0101};
  logic        vco [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  cla_pipe_adder #(.nBITS(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ain       (ain),
    .bin       (bin),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CLA_PIPE_FLAGS_EN
    ,
    .ovf       (ovf),
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: bench did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                               input logic c, input logic s);
    in_valid = v;
    ain      = a;
    bin      = b;
    cin      = c;
    sub      = s;
    #1;
  endtask

  task automatic applyBeat(input int k);
    applyStimulus(1'b1, va[k], vb[k], vci[k], vsb[k]);
  endtask

  task automatic applyIdle;
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic [15:0] es, input logic ec);
    checkBit({tag, ".valid"}, out_valid, ev);
    checkWord({tag, ".sum"}, sum, es);
    checkBit({tag, ".cout"}, cout, ec);
  endtask

  // One isolated operation: accept, verify exact 4-cycle latency, then drain.
  task automatic runSingle(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic c, input logic s, input logic [15:0] es, input logic ec,
                           input logic eovf, input logic ezero);
    applyStimulus(1'b1, a, b, c, s);
    checkBit({tag, ".in_ready"}, in_ready, 1'b1);
    stepCycle;
    applyIdle;
    stepCycle;
    stepCycle;
    checkBit({tag, ".early"}, out_valid, 1'b0);
    stepCycle;
    checkOutput(tag, 1'b1, es, ec);
`ifdef CLA_PIPE_FLAGS_EN
    checkBit({tag, ".ovf"}, ovf, eovf);
    checkBit({tag, ".zero"}, zero, ezero);
`else
    if (eovf !== ezero) begin end
`endif
    stepCycle;
    checkBit({tag, ".drain"}, out_valid, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    applyIdle;
    stepCycle;
    stepCycle;
    checkBit("rst.in_ready", in_ready, 1'b0);
    checkOutput("rst", 1'b0, 16'h0000, 1'b0);
`ifdef CLA_PIPE_FLAGS_EN
    checkBit("rst.ovf", ovf, 1'b0);
    checkBit("rst.zero", zero, 1'b0);
`endif
    reset = 1'b0;
    #1;
    checkBit("rst.release_ready", in_ready, 1'b1);
    stepCycle;

    runSingle("t1_add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    runSingle("t2_sub",      16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    runSingle("t3_ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

    // Streaming: eight back-to-back beats, results in order starting after the fourth edge.
    for (int k = 0; k < 12; k++) begin
      if (k < 8) applyBeat(k);
      else applyIdle;
      checkBit($sformatf("t4.in_ready[%0d]", k), in_ready, 1'b1);
      stepCycle;
      if (k >= 3 && k <= 10) checkOutput($sformatf("t4.beat%0d", k - 3), 1'b1, vs[k-3], vco[k-3]);
      else checkBit($sformatf("t4.idle[%0d]", k), out_valid, 1'b0);
    end

    // Backpressure: fill, stall three cycles with a beat waiting, then release.
    for (int k = 0; k < 4; k++) begin
      applyBeat(k);
      stepCycle;
    end
    checkOutput("t5.full", 1'b1, vs[0], vco[0]);
    out_ready = 1'b0;
    applyBeat(4);
    checkBit("t5.stall_ready", in_ready, 1'b0);
    for (int j = 0; j < 3; j++) begin
      stepCycle;
      checkOutput($sformatf("t5.hold%0d", j), 1'b1, vs[0], vco[0]);
      checkBit($sformatf("t5.hold_ready%0d", j), in_ready, 1'b0);
    end
    out_ready = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      if (j <= 4) applyBeat(j + 3);
      else applyIdle;
      checkBit($sformatf("t5.rel_ready%0d", j), in_ready, 1'b1);
      stepCycle;
      if (j <= 7) checkOutput($sformatf("t5.out%0d", j), 1'b1, vs[j], vco[j]);
      else checkBit("t5.empty", out_valid, 1'b0);
    end

    // Reset with three beats in flight: nothing stale may ever come out.
    for (int k = 0; k < 3; k++) begin
      applyBeat(k);
      stepCycle;
    end
    applyIdle;
    reset = 1'b1;
    #1;
    checkBit("t6.rst_ready", in_ready, 1'b0);
    stepCycle;
    reset = 1'b0;
    #1;
    checkOutput("t6.flushed", 1'b0, 16'h0000, 1'b0);
    for (int j = 0; j < 6; j++) begin
      stepCycle;
      checkBit($sformatf("t6.no_stale%0d", j), out_valid, 1'b0);
    end
    applyBeat(5);
    checkBit("t6.first_ready", in_ready, 1'b1);
    stepCycle;
    applyIdle;
    stepCycle;
    stepCycle;
    stepCycle;
    checkOutput("t6.first", 1'b1, vs[5], vco[5]);
    stepCycle;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
